alu_operand_stage: RTL and testbench



---
 rtl/alu_operand_stage.sv | 196 +++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode/execute pipeline register in front of the ALU.
// It decodes ALUOp/funct3/funct7b5/op5 into the 3-bit ALUcontrol and
// resolves the operand-B mux before the register. A, B, ALUcontrol and
// illegal then come straight from flops.
// The optional macro ALU_OPERAND_SKID_EN adds a one-entry skid buffer. With
// it, in_ready comes from a flop. Without it, in_ready is combinational.
module alu_operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] RD1,
   input  logic [31:0] RD2,
   input  logic [31:0] ImmExt,
   input  logic        ALUSrc,
   input  logic [1:0]  ALUOp,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        op5,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [2:0]  ALUcontrol,
   output logic        illegal,
   output logic [15:0] stall_cnt
);

   localparam logic [2:0] CTL_ADD = 3'b000;
   localparam logic [2:0] CTL_SUB = 3'b001;
   localparam logic [2:0] CTL_AND = 3'b010;
   localparam logic [2:0] CTL_OR  = 3'b011;

   logic [2:0]  dec_ctl;
   logic        dec_ill;
   logic [31:0] b_mux;
   logic        in_fire;
   logic        out_fire;

   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  ctl_q, ctl_d;
   logic        ill_q, ill_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] stall_q, stall_d;

   // ALU operation decode; undecodable ops fall back to add and flag illegal
   always_comb begin
      dec_ctl = CTL_ADD;
      dec_ill = 1'b0;
      case (ALUOp)
         2'b00: dec_ctl = CTL_ADD;
         2'b01: dec_ctl = CTL_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  dec_ctl = (op5 && funct7b5) ? CTL_SUB : CTL_ADD;
               3'b110:  dec_ctl = CTL_OR;
               3'b111:  dec_ctl = CTL_AND;
               default: dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
   end

   assign b_mux    = ALUSrc ? ImmExt : RD2;
   assign out_fire = out_valid_q && out_ready;
   assign in_fire  = in_valid && in_ready;

`ifdef ALU_OPERAND_SKID_EN
   logic [31:0] sk_a_q, sk_a_d;
   logic [31:0] sk_b_q, sk_b_d;
   logic [2:0]  sk_ctl_q, sk_ctl_d;
   logic        sk_ill_q, sk_ill_d;
   logic        sk_valid_q, sk_valid_d;

   // Accept only while the skid entry is empty, so in_ready is a flop output
   assign in_ready = !sk_valid_q;

   // Output register refills from skid first, then from input; a stalled arrival parks in skid
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      ctl_d       = ctl_q;
      ill_d       = ill_q;
      out_valid_d = out_valid_q;
      sk_a_d      = sk_a_q;
      sk_b_d      = sk_b_q;
      sk_ctl_d    = sk_ctl_q;
      sk_ill_d    = sk_ill_q;
      sk_valid_d  = sk_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
         sk_valid_d  = 1'b0;
      end else if (!out_valid_q || out_fire) begin
         if (sk_valid_q) begin
            a_d         = sk_a_q;
            b_d         = sk_b_q;
            ctl_d       = sk_ctl_q;
            ill_d       = sk_ill_q;
            out_valid_d = 1'b1;
            sk_valid_d  = 1'b0;
         end else if (in_fire) begin
            a_d         = RD1;
            b_d         = b_mux;
            ctl_d       = dec_ctl;
            ill_d       = dec_ill;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         sk_a_d     = RD1;
         sk_b_d     = b_mux;
         sk_ctl_d   = dec_ctl;
         sk_ill_d   = dec_ill;
         sk_valid_d = 1'b1;
      end
   end

   // Skid entry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sk_a_q     <= '0;
         sk_b_q     <= '0;
         sk_ctl_q   <= CTL_ADD;
         sk_ill_q   <= 1'b0;
         sk_valid_q <= 1'b0;
      end else begin
         sk_a_q     <= sk_a_d;
         sk_b_q     <= sk_b_d;
         sk_ctl_q   <= sk_ctl_d;
         sk_ill_q   <= sk_ill_d;
         sk_valid_q <= sk_valid_d;
      end
   end
`else
   // Free to accept when empty or the held instruction leaves this cycle
   assign in_ready = !out_valid_q || out_ready;

   // Single output register: flush wins, then load, then drain
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      ctl_d       = ctl_q;
      ill_d       = ill_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (in_fire) begin
         a_d         = RD1;
         b_d         = b_mux;
         ctl_d       = dec_ctl;
         ill_d       = dec_ill;
         out_valid_d = 1'b1;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   // Saturating count of cycles where the held result is not consumed
   always_comb begin
      stall_d = stall_q;
      if (out_valid_q && !out_ready && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   // Output and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         ctl_q       <= CTL_ADD;
         ill_q       <= 1'b0;
         out_valid_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         ctl_q       <= ctl_d;
         ill_q       <= ill_d;
         out_valid_q <= out_valid_d;
         stall_q     <= stall_d;
      end
   end

   assign A          = a_q;
   assign B          = b_q;
   assign ALUcontrol = ctl_q;
   assign illegal    = ill_q;
   assign out_valid  = out_valid_q;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage in its default single-register build.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] RD1, RD2, ImmExt;
   logic        ALUSrc;
   logic [1:0]  ALUOp;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        op5;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] A, B;
   logic [2:0]  ALUcontrol;
   logic        illegal;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
      .funct3(funct3), .funct7b5(funct7b5), .op5(op5), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
      .ALUcontrol(ALUcontrol), .illegal(illegal), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        o5;
      logic        src;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [2:0]  ec;
      logic        ei;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ALUOp    = v.op;
      funct3   = v.f3;
      funct7b5 = v.f7;
      op5      = v.o5;
      ALUSrc   = v.src;
      RD1      = v.rd1;
      RD2      = v.rd2;
      ImmExt   = v.imm;
   endtask

   task automatic chk_vec(input int i, input vec_t v);
      string s;
      s = $sformatf("vec%0d", i);
      chk({s, " out_valid"}, 32'(out_valid), 32'd1);
      chk({s, " A"}, A, v.ea);
      chk({s, " B"}, B, v.eb);
      chk({s, " ALUcontrol"}, 32'(ALUcontrol), 32'(v.ec));
      chk({s, " illegal"}, 32'(illegal), 32'(v.ei));
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                               input logic o5, input logic src, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [2:0] ec, input logic ei);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.o5 = o5; v.src = src;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
      v.ea = rd1; v.eb = src ? imm : rd2; v.ec = ec; v.ei = ei;
      return v;
   endfunction

   vec_t vx, vy, vz, vw;

   initial begin
      // op, f3, f7b5, op5, ALUSrc, RD1, RD2, ImmExt, expected ALUcontrol, expected illegal
      vq.push_back(mk(2'b10, 3'b000, 1, 1, 0, 32'd5,        32'd3,        32'h0,        3'b001, 0)); // sub
      vq.push_back(mk(2'b10, 3'b000, 1, 0, 1, 32'd5,        32'd3,        32'hFFFFFFFF, 3'b000, 0)); // addi
      vq.push_back(mk(2'b10, 3'b000, 0, 1, 0, 32'h10,       32'h20,       32'h55,       3'b000, 0)); // add
      vq.push_back(mk(2'b10, 3'b110, 0, 1, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        3'b011, 0)); // or
      vq.push_back(mk(2'b10, 3'b111, 1, 0, 1, 32'h12345678, 32'h0,        32'h000000FF, 3'b010, 0)); // andi
      vq.push_back(mk(2'b10, 3'b001, 0, 1, 0, 32'h1,        32'h2,        32'h0,        3'b000, 1)); // illegal f3
      vq.push_back(mk(2'b11, 3'b000, 0, 0, 0, 32'h3,        32'h4,        32'h0,        3'b000, 1)); // illegal op
      vq.push_back(mk(2'b00, 3'b111, 1, 1, 1, 32'h80000000, 32'h9,        32'h000007FF, 3'b000, 0)); // load/store add
      vq.push_back(mk(2'b01, 3'b110, 0, 0, 0, 32'h7,        32'hDEADBEEF, 32'h0,        3'b001, 0)); // branch sub
      vq.push_back(mk(2'b10, 3'b100, 0, 1, 0, 32'hCAFE,     32'hBEEF,     32'h0,        3'b000, 1)); // xor: illegal

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      drive(vq[0]);
      #12;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset A", A, 32'd0);
      chk("reset B", B, 32'd0);
      chk("reset ALUcontrol", 32'(ALUcontrol), 32'd0);
      chk("reset illegal", 32'(illegal), 32'd0);
      chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back decode vectors, one per cycle
      drive(vq[0]);
      in_valid = 1'b1;
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         chk_vec(i, vq[i]);
         if (i + 1 < vq.size()) drive(vq[i + 1]);
         else in_valid = 1'b0;
      end
      @(negedge clk);
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain A held", A, vq[vq.size() - 1].ea);

      // backpressure: X held for 4 stalled cycles while Y waits upstream
      vx = mk(2'b00, 3'b000, 0, 0, 0, 32'hAAAA0001, 32'h11110000, 32'h0, 3'b000, 0);
      vy = mk(2'b01, 3'b000, 0, 0, 0, 32'hBBBB0002, 32'h22220000, 32'h0, 3'b001, 0);
      out_ready = 1'b0;
      drive(vx);
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp load out_valid", 32'(out_valid), 32'd1);
      drive(vy);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d A frozen", k), A, vx.ea);
         chk($sformatf("bp%0d B frozen", k), B, vx.eb);
         chk($sformatf("bp%0d ctl frozen", k), 32'(ALUcontrol), 32'(vx.ec));
         chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
      end
      chk("bp stall_cnt", 32'(stall_cnt), 32'd4);
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("bp Y out_valid", 32'(out_valid), 32'd1);
      chk("bp Y A", A, vy.ea);
      chk("bp Y ALUcontrol", 32'(ALUcontrol), 32'(vy.ec));
      chk("bp stall_cnt kept", 32'(stall_cnt), 32'd4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp no duplicate", 32'(out_valid), 32'd0);
      chk("bp A held", A, vy.ea);

      // flush with a held instruction and a new one arriving
      vz = mk(2'b00, 3'b000, 0, 0, 0, 32'h00000100, 32'h7, 32'h0, 3'b000, 0);
      vw = mk(2'b10, 3'b110, 0, 1, 0, 32'h00000321, 32'hF0, 32'h0, 3'b011, 0);
      drive(vz);
      in_valid = 1'b1;
      @(negedge clk);
      chk("flush pre out_valid", 32'(out_valid), 32'd1);
      flush = 1'b1;
      drive(vy);
      @(negedge clk);
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush stall_cnt", 32'(stall_cnt), 32'd4);
      flush = 1'b0;
      drive(vw);
      @(negedge clk);
      chk("post-flush out_valid", 32'(out_valid), 32'd1);
      chk("post-flush A", A, vw.ea);
      chk("post-flush B", B, vw.eb);
      chk("post-flush ALUcontrol", 32'(ALUcontrol), 32'(vw.ec));

      // asynchronous reset while an instruction is held and stalled
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre-reset stall_cnt", 32'(stall_cnt), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'd0);
      chk("async reset A", A, 32'd0);
      chk("async reset B", B, 32'd0);
      chk("async reset ALUcontrol", 32'(ALUcontrol), 32'd0);
      chk("async reset stall_cnt", 32'(stall_cnt), 32'd0);
      chk("async reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after reset out_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
